// File: rtl/branch_flush_ctrl.sv
// rtl/branch_flush_ctrl.sv - execute-stage stall/flush/PC-select control with PC-write tracker and squash counter
module branch_flush_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             armE,
  input  logic             PCSrcD,
  input  logic             PCSrcE,
  input  logic [1:0]       BranchTakenE,
  input  logic             LoadUseStall,
  input  logic             MemStall,
  input  logic             CountClr,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       PCSelF,
  output logic [CNT_W-1:0] SquashCount
);

  localparam logic [CNT_W+1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

  logic             pendM_q, pendM_d;
  logic             pendW_q, pendW_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             taken_e;
  logic             pc_wr_e;
  logic             pend;
  logic [CNT_W+1:0] cnt_sum;

  // A taken branch in E overrides any result-based PC write from the same instruction;
  // RISC-V never redirects through the result path.
  assign taken_e = (BranchTakenE != 2'b00);
  assign pc_wr_e = PCSrcE & armE & ~taken_e;
  assign pend    = PCSrcD | pc_wr_e | pendM_q;

  // Priority-ordered stall/flush/redirect decode; a frozen pipeline wins over everything.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    PCSelF = 2'b00;
    if (MemStall) begin
      StallF = 1'b1;
      StallD = 1'b1;
    end else if (taken_e) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      PCSelF = 2'b01;
    end else if (pendW_q) begin
      FlushD = 1'b1;
      PCSelF = 2'b10;
    end else if (LoadUseStall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end else if (pend) begin
      StallF = 1'b1;
      FlushD = 1'b1;
    end
  end

  // Next state: PC-write tracker advances only when the pipeline moves; counter saturates.
  always_comb begin
    pendM_d = pendM_q;
    pendW_d = pendW_q;
    if (!MemStall) begin
      pendM_d = pc_wr_e;
      pendW_d = pendM_q;
    end
    cnt_sum = {2'b00, cnt_q}
            + {{(CNT_W+1){1'b0}}, FlushD}
            + {{(CNT_W+1){1'b0}}, FlushE};
    if (CountClr) begin
      cnt_d = '0;
    end else if (cnt_sum > CNT_MAX) begin
      cnt_d = CNT_MAX[CNT_W-1:0];
    end else begin
      cnt_d = cnt_sum[CNT_W-1:0];
    end
  end

  // State registers; reset drops any in-flight PC write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pendM_q <= 1'b0;
      pendW_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pendM_q <= pendM_d;
      pendW_q <= pendW_d;
      cnt_q   <= cnt_d;
    end
  end

  assign SquashCount = cnt_q;

endmodule

// File: tb/tb_branch_flush_ctrl.sv
// tb/tb_branch_flush_ctrl.sv - scoreboard testbench for branch_flush_ctrl
module tb_branch_flush_ctrl;

  localparam int CW = 4;
  localparam int VW = 6 + CW;

  logic          clk = 1'b0;
  logic          reset;
  logic          armE, PCSrcD, PCSrcE, LoadUseStall, MemStall, CountClr;
  logic [1:0]    BranchTakenE;
  logic          StallF, StallD, FlushD, FlushE;
  logic [1:0]    PCSelF;
  logic [CW-1:0] SquashCount;

  branch_flush_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .armE(armE), .PCSrcD(PCSrcD), .PCSrcE(PCSrcE),
    .BranchTakenE(BranchTakenE), .LoadUseStall(LoadUseStall), .MemStall(MemStall),
    .CountClr(CountClr), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .FlushE(FlushE), .PCSelF(PCSelF), .SquashCount(SquashCount)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit active = 1'b0;

  logic [VW-1:0] exp_q[$];
  int            tag_q[$];

  // Reference model: ages (in pipeline advances) of outstanding ARM PC writes, plus a count.
  int m_age[$];
  int m_cnt;

  function automatic bit has_age(input int a);
    foreach (m_age[i]) if (m_age[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive(input bit rst_n, input bit ae, input bit pd, input bit pe,
                       input bit [1:0] bt, input bit lu, input bit ms, input bit clr);
    bit sf, sd, fd, fe, taken, wr_e, pnd;
    bit [1:0] sel;
    int nxt[$];
    int sum;
    @(posedge clk);
    #1;
    reset = rst_n; armE = ae; PCSrcD = pd; PCSrcE = pe; BranchTakenE = bt;
    LoadUseStall = lu; MemStall = ms; CountClr = clr;
    if (!rst_n) begin
      m_age.delete();
      m_cnt = 0;
    end
    sf = 0; sd = 0; fd = 0; fe = 0; sel = 2'd0;
    taken = (bt != 0);
    wr_e  = pe && ae && !taken;
    pnd   = pd || wr_e || has_age(1);
    if (ms)                 begin sf = 1; sd = 1; end
    else if (taken)         begin fd = 1; fe = 1; sel = 2'd1; end
    else if (has_age(2))    begin fd = 1; sel = 2'd2; end
    else if (lu)            begin sf = 1; sd = 1; fe = 1; end
    else if (pnd)           begin sf = 1; fd = 1; end
    exp_q.push_back({sf, sd, fd, fe, sel, m_cnt[CW-1:0]});
    tag_q.push_back(cyc);
    cyc++;
    if (rst_n) begin
      if (!ms) begin
        foreach (m_age[i]) if (m_age[i] + 1 <= 2) nxt.push_back(m_age[i] + 1);
        if (wr_e) nxt.push_back(1);
        m_age = nxt;
      end
      sum = m_cnt + int'(fd) + int'(fe);
      m_cnt = clr ? 0 : ((sum > (1 << CW) - 1) ? (1 << CW) - 1 : sum);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 2'b00, 0, 0, 0);
  endtask

  // Monitor: one expected vector per cycle, compared mid-cycle.
  initial begin
    logic [VW-1:0] act, ex;
    int t;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        ex = exp_q.pop_front();
        t  = tag_q.pop_front();
        act = {StallF, StallD, FlushD, FlushE, PCSelF, SquashCount};
        total++;
        if (act !== ex) begin
          bad++;
          $display("FAIL outputs cycle=%0d got SF/SD/FD/FE/sel/cnt=%b/%b/%b/%b/%b/%0d want %b/%b/%b/%b/%b/%0d",
                   t, act[VW-1], act[VW-2], act[VW-3], act[VW-4], act[CW+1:CW], act[CW-1:0],
                   ex[VW-1], ex[VW-2], ex[VW-3], ex[VW-4], ex[CW+1:CW], ex[CW-1:0]);
        end
      end else if (active) begin
        total++;
        bad++;
        $display("FAIL scoreboard cycle=%0d got empty queue want one expectation", cyc);
      end
    end
  end

  initial begin
    reset = 0; armE = 0; PCSrcD = 0; PCSrcE = 0; BranchTakenE = 0;
    LoadUseStall = 0; MemStall = 0; CountClr = 0;
    m_cnt = 0;
    drive(0, 0, 0, 0, 2'b00, 0, 0, 0);
    active = 1'b1;
    idle(2);
    // taken branch in RISC-V mode
    drive(1, 0, 0, 0, 2'b01, 0, 0, 0);
    idle(2);
    // ARM PC write through result
    drive(1, 1, 0, 1, 2'b00, 0, 0, 0);
    idle(4);
    // same, with a two-cycle memory stall behind it
    drive(1, 1, 0, 1, 2'b00, 0, 0, 0);
    drive(1, 0, 0, 0, 2'b00, 0, 1, 0);
    drive(1, 0, 0, 0, 2'b00, 0, 1, 0);
    idle(4);
    // RISC-V ignores PCSrcE; taken branch drops a simultaneous PCSrcE
    drive(1, 0, 0, 1, 2'b00, 0, 0, 0);
    drive(1, 1, 0, 1, 2'b10, 0, 0, 0);
    idle(3);
    // load-use with PCSrcD, then PCSrcD alone
    drive(1, 1, 1, 0, 2'b00, 1, 0, 0);
    drive(1, 1, 1, 0, 2'b00, 0, 0, 0);
    idle(1);
    // saturation and clear
    for (int i = 0; i < 8; i++) drive(1, 0, 0, 0, 2'b11, 0, 0, 0);
    idle(1);
    drive(1, 0, 0, 0, 2'b00, 0, 0, 1);
    idle(1);
    // reset while a PC write sits in M
    drive(1, 1, 0, 1, 2'b00, 0, 0, 0);
    drive(0, 0, 0, 0, 2'b00, 0, 0, 0);
    idle(4);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 199) != 0),
            $urandom_range(0, 1),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 3) == 0),
            (($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 40) == 0));
    end
    @(posedge clk);
    #1;
    active = 1'b0;
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain got %0d leftover want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
